// File: rtl/inject_arb_rr.sv
// Injection arbiter: picks one free, active output slot for a locally generated flit,
// round-robin or fixed priority. Define INJECT_STARVE_EN to build the starvation monitor.
module inject_arb_rr #(
   parameter int NUM_PORT       = 4,
   parameter int PORT_STAT_SIZE = 2,
   parameter int ACTIVE_CODE    = 1,
   parameter int RR_MODE        = 1,
   parameter int STARVE_LIMIT   = 15
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_PORT-1:0]                valid,
   input  logic [NUM_PORT*PORT_STAT_SIZE-1:0] portStatus,
   input  logic                               injectReq,
   output logic [NUM_PORT-1:0]                grant,
   output logic                               injectGrant,
   output logic                               injectStarve
);

   localparam int PTR_W = $clog2(NUM_PORT);

   if (NUM_PORT < 2 || NUM_PORT > 16) begin : gBadNumPort
      $error("inject_arb_rr: NUM_PORT must be in 2..16");
   end
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : gBadStarveLimit
      $error("inject_arb_rr: STARVE_LIMIT must be in 1..255");
   end
   if (RR_MODE != 0 && RR_MODE != 1) begin : gBadRrMode
      $error("inject_arb_rr: RR_MODE must be 0 or 1");
   end

   logic [NUM_PORT-1:0] cand;
   logic [PTR_W-1:0]    ptr;
   logic [PTR_W-1:0]    ptrNext;
   logic [PTR_W-1:0]    grantIdx;
   logic                found;

   always_comb begin
      cand = '0;
      for (int i = 0; i < NUM_PORT; i++) begin
         cand[i] = ~valid[i] &
                   (portStatus[i*PORT_STAT_SIZE +: PORT_STAT_SIZE] == PORT_STAT_SIZE'(ACTIVE_CODE));
      end
   end

   // Search NUM_PORT positions starting at ptr (or at 0 in fixed-priority mode);
   // the sum is one bit wider so the wrap works for non-power-of-two port counts.
   always_comb begin
      logic [PTR_W:0] pos;
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      pos      = '0;
      found    = 1'b0;
      grantIdx = '0;
      grant    = '0;
      for (int off = 0; off < NUM_PORT; off++) begin
         if (RR_MODE != 0) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(off);
            if (pos >= (PTR_W+1)'(NUM_PORT)) begin
               pos = pos - (PTR_W+1)'(NUM_PORT);
            end
         end else begin
            pos = (PTR_W+1)'(off);
         end
         if (!found && cand[pos[PTR_W-1:0]]) begin
            found    = 1'b1;
            grantIdx = pos[PTR_W-1:0];
         end
      end
      if (found && injectReq && !reset) begin
         grant[grantIdx] = 1'b1;
      end
   end

   assign injectGrant = |grant;
   assign ptrNext     = (grantIdx == PTR_W'(NUM_PORT-1)) ? '0 : grantIdx + 1'b1;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (injectGrant) begin
         ptr <= ptrNext;
      end
   end

`ifdef INJECT_STARVE_EN
   logic [7:0] starveCnt;

   // A grant or an idle request clears the count; only a blocked cycle advances it.
   always_ff @(posedge clk) begin
      if (reset) begin
         starveCnt <= '0;
      end else if (injectReq && !injectGrant) begin
         if (starveCnt != 8'(STARVE_LIMIT)) begin
            starveCnt <= starveCnt + 8'd1;
         end
      end else begin
         starveCnt <= '0;
      end
   end

   assign injectStarve = (starveCnt == 8'(STARVE_LIMIT));
`else
   assign injectStarve = 1'b0;
`endif

   gOneHotGrant : assert property (@(posedge clk) $onehot0(grant));

endmodule
